// File: rtl/x_pkg.sv
// x_pkg: shared types and widths for the sample playback slice.
//   player_state_t : playback sequencer states
//   ADDR_W / DATA_W / DIV_W : default address, sample and divider widths
//   MIN_DIV        : smallest usable period divider (fetch/capture/commit
//                    each need their own cycle, so a period is >= 3 cycles)
package x_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } player_state_t;

   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned DATA_W  = 6;
   localparam int unsigned DIV_W   = 16;
   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/x_mem_arb.sv
// x_mem_arb: single-port memory arbitration between the playback fetch and
// the host (UART command) port.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_fetch             : player owns the port this cycle (fixed priority)
//   i_fetch_addr        : player fetch address
//   i_host_req/addr/we/wdata : host access, request held until granted
//   i_mem_rdata         : registered memory read data (1-cycle latency)
//   o_host_gnt          : combinational grant, access happens this cycle
//   o_host_rvalid/rdata : host read result, one cycle after a granted read
//   o_mem_addr/we/wdata : memory port
module x_mem_arb
   import x_pkg::*;
#(
   parameter int unsigned p_addr_w = ADDR_W,
   parameter int unsigned p_data_w = DATA_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_fetch,
   input  logic [p_addr_w-1:0] i_fetch_addr,
   input  logic                i_host_req,
   input  logic [p_addr_w-1:0] i_host_addr,
   input  logic                i_host_we,
   input  logic [p_data_w-1:0] i_host_wdata,
   input  logic [p_data_w-1:0] i_mem_rdata,
   output logic                o_host_gnt,
   output logic                o_host_rvalid,
   output logic [p_data_w-1:0] o_host_rdata,
   output logic [p_addr_w-1:0] o_mem_addr,
   output logic                o_mem_we,
   output logic [p_data_w-1:0] o_mem_wdata
);

   logic rvalid_r;

   always_comb begin
      o_host_gnt  = i_host_req & ~i_fetch;
      o_mem_addr  = '0;
      o_mem_we    = 1'b0;
      o_mem_wdata = '0;
      if (i_fetch) begin
         o_mem_addr = i_fetch_addr;
      end else if (o_host_gnt) begin
         o_mem_addr  = i_host_addr;
         o_mem_we    = i_host_we;
         o_mem_wdata = i_host_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= o_host_gnt & ~i_host_we;
      end
   end

   // Memory output is already registered, so the read result is simply the
   // memory data in the cycle after the grant; zero otherwise.
   assign o_host_rvalid = rvalid_r;
   assign o_host_rdata  = rvalid_r ? i_mem_rdata : '0;

endmodule

// File: rtl/x_player.sv
// x_player: sample playback sequencer. Streams samples from the sample
// memory to the thermometer encoder at one sample per (div+1) cycles and
// shares the memory port with the host.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_start / i_stop           : begin (when idle) / abort playback; stop wins
//   i_loop                     : wrap to start address after end address
//   i_start_addr / i_end_addr  : playback range, end inclusive
//   i_div                      : period minus 1, clamped to >= MIN_DIV
//   i_host_*, o_host_*         : host memory access (see x_mem_arb)
//   o_mem_*, i_mem_rdata       : sample memory port
//   o_bin                      : current sample
//   o_busy                     : playback active
//   o_wrap                     : 1-cycle pulse when a loop pass wraps
module x_player
   import x_pkg::*;
#(
   parameter int unsigned p_addr_w = ADDR_W,
   parameter int unsigned p_data_w = DATA_W,
   parameter int unsigned p_div_w  = DIV_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_loop,
   input  logic [p_addr_w-1:0] i_start_addr,
   input  logic [p_addr_w-1:0] i_end_addr,
   input  logic [p_div_w-1:0]  i_div,
   input  logic                i_host_req,
   input  logic [p_addr_w-1:0] i_host_addr,
   input  logic                i_host_we,
   input  logic [p_data_w-1:0] i_host_wdata,
   output logic                o_host_gnt,
   output logic                o_host_rvalid,
   output logic [p_data_w-1:0] o_host_rdata,
   output logic [p_addr_w-1:0] o_mem_addr,
   output logic                o_mem_we,
   output logic [p_data_w-1:0] o_mem_wdata,
   input  logic [p_data_w-1:0] i_mem_rdata,
   output logic [p_data_w-1:0] o_bin,
   output logic                o_busy,
   output logic                o_wrap
);

   // Period counter phases: fetch at 2, capture at 1, commit at 0.
   localparam logic [p_div_w-1:0] CNT_FETCH   = p_div_w'(2);
   localparam logic [p_div_w-1:0] CNT_CAPTURE = p_div_w'(1);
   localparam logic [p_div_w-1:0] DIV_FLOOR   = p_div_w'(MIN_DIV);

   player_state_t        state, state_nxt;
   logic [p_div_w-1:0]   cnt, div_r, div_clamped;
   logic [p_addr_w-1:0]  addr, start_r, end_r;
   logic [p_data_w-1:0]  sbuf, bin_r;
   logic                 loop_r, last, wrap_r;
   logic                 start_go, run, fetch, capture, commit;

   assign div_clamped = (i_div < DIV_FLOOR) ? DIV_FLOOR : i_div;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_go  = 1'b0;
      fetch     = (state == PLAY) && (cnt == CNT_FETCH);
      capture   = (state == PLAY) && (cnt == CNT_CAPTURE);
      commit    = (state == PLAY) && (cnt == '0);
      run       = (state == PLAY) && !i_stop;
      case (state)
         IDLE: begin
            if (i_start && !i_stop) begin
               state_nxt = PLAY;
               start_go  = 1'b1;
            end
         end
         PLAY: begin
            if (i_stop || (commit && last)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A stop cycle suppresses every datapath update, so the in-flight sample
   // is dropped and o_bin keeps its last committed value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt     <= '0;
         div_r   <= '0;
         addr    <= '0;
         start_r <= '0;
         end_r   <= '0;
         loop_r  <= 1'b0;
         last    <= 1'b0;
         sbuf    <= '0;
         bin_r   <= '0;
         wrap_r  <= 1'b0;
      end else begin
         wrap_r <= 1'b0;
         if (start_go) begin
            start_r <= i_start_addr;
            end_r   <= i_end_addr;
            div_r   <= div_clamped;
            loop_r  <= i_loop;
            addr    <= i_start_addr;
            cnt     <= CNT_FETCH;
            last    <= 1'b0;
         end else if (run) begin
            cnt <= (cnt == '0) ? div_r : cnt - 1'b1;
            if (fetch) begin
               if (addr != end_r) begin
                  addr <= addr + 1'b1;
               end else if (loop_r) begin
                  addr   <= start_r;
                  wrap_r <= 1'b1;
               end else begin
                  last <= 1'b1;
               end
            end
            if (capture) begin
               sbuf <= i_mem_rdata;
            end
            if (commit) begin
               bin_r <= sbuf;
            end
         end
      end
   end

   assign o_bin  = bin_r;
   assign o_busy = (state == PLAY);
   assign o_wrap = wrap_r;

   x_mem_arb #(
      .p_addr_w (p_addr_w),
      .p_data_w (p_data_w)
   ) u_arb (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_fetch       (fetch),
      .i_fetch_addr  (addr),
      .i_host_req    (i_host_req),
      .i_host_addr   (i_host_addr),
      .i_host_we     (i_host_we),
      .i_host_wdata  (i_host_wdata),
      .i_mem_rdata   (i_mem_rdata),
      .o_host_gnt    (o_host_gnt),
      .o_host_rvalid (o_host_rvalid),
      .o_host_rdata  (o_host_rdata),
      .o_mem_addr    (o_mem_addr),
      .o_mem_we      (o_mem_we),
      .o_mem_wdata   (o_mem_wdata)
   );

endmodule

// File: doc/x_player.md
# x_player

Sample playback sequencer with memory-port arbitration. It streams 6-bit DAC samples from the sample memory to the binary-to-thermometer stage at a programmable rate, and shares the memory's single port with the UART command controller. It sits between `x_ctrl`, `x_mem` and `x_bin_to_therm`.

## Interface
- `p_addr_w`, 11: memory address width (2048 samples).
- `p_data_w`, 6: sample width.
- `p_div_w`, 16: sample-period divider width.
- `i_clk` in 1: the single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: pulse that begins playback when idle.
- `i_stop` in 1: pulse that aborts playback.
- `i_loop` in 1: wrap to the start address after the end address.
- `i_start_addr` in p_addr_w: first sample address.
- `i_end_addr` in p_addr_w: last sample address, inclusive.
- `i_div` in p_div_w: sample period in cycles minus 1; values below 2 are clamped to 2.
- `i_host_req` in 1: host access request, level, held until granted.
- `i_host_addr` in p_addr_w, `i_host_we` in 1, `i_host_wdata` in p_data_w: host access.
- `o_host_gnt` out 1: combinational grant; the access happens in this cycle.
- `o_host_rvalid` out 1: `o_host_rdata` valid; pulses 1 cycle after a granted read.
- `o_host_rdata` out p_data_w: host read data.
- `o_mem_addr` out p_addr_w, `o_mem_we` out 1, `o_mem_wdata` out p_data_w: memory port, combinational mux.
- `i_mem_rdata` in p_data_w: registered memory read data, valid 1 cycle after its address.
- `o_bin` out p_data_w: current sample, to the thermometer encoder.
- `o_busy` out 1: playback active.
- `o_wrap` out 1: 1-cycle pulse when the address wraps in loop mode.

## Operation
- States are IDLE and PLAY.
- **Starting playback.** In IDLE, `i_start` latches `i_start_addr`, `i_end_addr`, the clamped `i_div` and `i_loop`.
  - It sets `addr` to the start address and `cnt` to 2, then enters PLAY.
  - Inputs that change during PLAY have no effect.
- **Period counter.** In PLAY, `cnt` decrements every cycle and reloads the latched div at 0, giving a period of div+1 cycles.
- **Fetch cycle (`cnt`==2).** The player owns the memory port, with `o_mem_addr`=`addr` and `o_mem_we`=0.
- **Capture cycle (`cnt`==1).** `i_mem_rdata` is captured into the sample buffer.
- **Commit cycle (`cnt`==0).** The buffer is registered into `o_bin` at the end of the cycle.
- **Address advance.** This happens in the fetch cycle.
  - If `addr`≠end, `addr` increments modulo 2^p_addr_w. An end address below the start address therefore wraps through 2047→0.
  - If `addr`==end and loop is set, `addr` returns to start and `o_wrap` pulses for 1 cycle, registered, in the next cycle.
  - If `addr`==end and loop is clear, the `last` flag is set. After the commit of the last sample, the block returns to IDLE.
- **Stopping.** `i_stop` in PLAY returns to IDLE at the next edge. `o_bin` holds its value and the in-flight sample is discarded.
  - `i_start` and `i_stop` high together means stop wins.
  - `i_start` in PLAY is ignored.
- **Arbitration.**
  - The player fetch has fixed priority over the host.
  - `o_host_gnt` = `i_host_req` & ~(PLAY & `cnt`==2).
  - When the host is granted, the mux routes the host's addr, we and wdata to the memory.
  - A granted host read gives `o_host_rvalid` and `o_host_rdata` in the next cycle.
  - A host write in a player capture cycle does not corrupt the capture, because the capture uses the previous cycle's read.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. `cnt`, `addr`, the buffer and `last` are 0.
- **Reset mid-playback.** The block returns to IDLE next cycle with `o_bin`=0.
- **Latency from `i_start` (cycle T) to the first sample.**
  - Fetch at T+1.
  - Capture at T+2.
  - `o_bin` updates at the T+3 edge, visible in T+4.
- **Playback rate.** After the first sample, `o_bin` changes every div+1 cycles.
- **Busy flag.** `o_busy` rises at T+1. It falls in the cycle after the final commit, or the cycle after `i_stop`.
- **Host stall.** A host request is stalled at most 1 cycle per sample period.

## Structure
- **`x_pkg`:**
  - `player_state_t` enum {IDLE, PLAY};
  - `ADDR_W`, `DATA_W`, `DIV_W` localparams;
  - `MIN_DIV`=2.
- **`x_mem_arb` sub-module:** holds the combinational grant/mux plus the host `rvalid` register.
- **`x_player`:** holds the FSM, the counter, the address and the buffer.

## Test plan
- **Single pass.** Memory [10]=5, [11]=9, [12]=63; start=10, end=12, div=3, loop=0.
  - `o_bin` reads 5, 9, 63, changing every 4 cycles, with the first visible 4 cycles after start.
  - `o_busy` falls after 63 and `o_bin` holds 63.
- **Loop.** start=0, end=1, div=2, loop=1.
  - Sequence m[0], m[1], m[0], …
  - `o_wrap` pulses once per pass.
  - `i_stop` ends playback the next cycle with `o_bin` held.
- **Address wrap.** start=2046, end=1.
  - Addresses fetched are 2046, 2047, 0, 1, then the block returns to IDLE.
- **Arbitration.** Host reads are held high continuously during playback at div=2.
  - The grant drops exactly in each `cnt`==2 cycle.
  - `o_host_rvalid` follows each grant by 1 cycle with the correct data.
  - The player samples are unaffected.
- **Edge inputs.**
  - div=0 behaves as div=2.
  - `i_start` together with `i_stop` stays IDLE.
  - `i_start` during PLAY is ignored.
  - `i_rst` mid-play zeroes all outputs.
